// File: rtl/dmem_responder.sv
// Wait-stated data-memory responder: one request at a time over valid/ready, response after WAIT_CYCLES.
// Optional misaligned-address error reporting is enabled with `define DMEM_MISALIGN_CHECK_EN.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;

  logic [31:0] mem_q [DEPTH];

  logic                  accept_s;
  logic                  enter_resp_s;
  logic                  acc_write_s;
  logic [31:0]           acc_addr_s;
  logic [31:0]           acc_wdata_s;
  logic                  acc_err_s;
  logic [ADDR_WIDTH-1:0] idx_s;
  logic                  mem_we_s;

  function automatic logic addr_error(input logic [31:0] addr);
    logic err;
    err = ((addr >> (ADDR_WIDTH + 2)) != 32'd0);
`ifdef DMEM_MISALIGN_CHECK_EN
    err = err | (addr[1:0] != 2'b00);
`endif
    return err;
  endfunction

`ifndef DMEM_MISALIGN_CHECK_EN
  logic unused_addr_lsb_s;
  assign unused_addr_lsb_s = &{1'b0, acc_addr_s[1:0]};
`endif

  assign req_ready  = (state_q == ST_IDLE) && rst;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_error = error_q;

  // With zero wait states the memory is accessed on the accept edge, so the live request is used.
  always_comb begin
    accept_s = req_valid && req_ready;
    if (state_q == ST_IDLE) begin
      acc_write_s = req_write;
      acc_addr_s  = req_addr;
      acc_wdata_s = req_wdata;
    end else begin
      acc_write_s = write_q;
      acc_addr_s  = addr_q;
      acc_wdata_s = wdata_q;
    end
    acc_err_s = addr_error(acc_addr_s);
    idx_s     = acc_addr_s[ADDR_WIDTH+1:2];
  end

  // Next-state, wait counter and response register computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    rdata_d      = rdata_q;
    error_d      = error_q;
    enter_resp_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d      = ST_RESP;
            enter_resp_s = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d      = ST_RESP;
          enter_resp_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        resp_valid_d = 1'b0;
      end
    endcase
    if (enter_resp_s) begin
      resp_valid_d = 1'b1;
      error_d      = acc_err_s;
      if (!acc_write_s && !acc_err_s) begin
        rdata_d = mem_q[idx_s];
      end else begin
        rdata_d = 32'd0;
      end
    end else begin
      error_d = error_q;
    end
    mem_we_s = enter_resp_s && acc_write_s && !acc_err_s;
  end

  // Control and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      write_q      <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'd0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      error_q      <= error_d;
    end
  end

  // Storage array; deliberately not reset so contents survive a reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[idx_s] <= acc_wdata_s;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance 0 uses WAIT_CYCLES=2, instance 1 uses WAIT_CYCLES=0.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid_a  [2];
  logic        req_ready_a  [2];
  logic        req_write_a  [2];
  logic [31:0] req_addr_a   [2];
  logic [31:0] req_wdata_a  [2];
  logic        resp_valid_a [2];
  logic        resp_ready_a [2];
  logic [31:0] resp_rdata_a [2];
  logic        resp_error_a [2];

  int tests;
  int fails;

  dmem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_a[0]), .req_ready(req_ready_a[0]), .req_write(req_write_a[0]),
    .req_addr(req_addr_a[0]), .req_wdata(req_wdata_a[0]),
    .resp_valid(resp_valid_a[0]), .resp_ready(resp_ready_a[0]),
    .resp_rdata(resp_rdata_a[0]), .resp_error(resp_error_a[0])
  );

  dmem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_a[1]), .req_ready(req_ready_a[1]), .req_write(req_write_a[1]),
    .req_addr(req_addr_a[1]), .req_wdata(req_wdata_a[1]),
    .resp_valid(resp_valid_a[1]), .resp_ready(resp_ready_a[1]),
    .resp_rdata(resp_rdata_a[1]), .resp_error(resp_error_a[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_reset_outputs(input string name);
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (req_ready_a[d] !== 1'b0 || resp_valid_a[d] !== 1'b0 ||
          resp_rdata_a[d] !== 32'd0 || resp_error_a[d] !== 1'b0) begin
        fails++;
        $display("FAIL %s dut%0d: ready=%b valid=%b rdata=%h err=%b, want 0 0 00000000 0",
                 name, d, req_ready_a[d], resp_valid_a[d], resp_rdata_a[d], resp_error_a[d]);
      end
    end
  endtask

  // One complete request/response; exp_lat counts falling edges after the accept edge.
  task automatic do_txn(input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int exp_lat,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int stall, input string name);
    int k;
    @(negedge clk);
    tests++;
    if (req_ready_a[d] !== 1'b1) begin
      fails++;
      $display("FAIL %s idle_ready: got %b want 1", name, req_ready_a[d]);
    end
    req_valid_a[d] = 1'b1;
    req_write_a[d] = wr;
    req_addr_a[d]  = addr;
    req_wdata_a[d] = wdata;
    @(posedge clk);
    #1;
    req_valid_a[d] = 1'b0;
    req_write_a[d] = ~wr;
    req_addr_a[d]  = 32'hFFFF_FFFC;
    req_wdata_a[d] = 32'hA5A5_A5A5;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (resp_valid_a[d] !== 1'b1 && k < 40);
    tests++;
    if (k != exp_lat) begin
      fails++;
      $display("FAIL %s latency: got %0d want %0d", name, k, exp_lat);
    end
    tests++;
    if (resp_rdata_a[d] !== exp_rdata || resp_error_a[d] !== exp_err || req_ready_a[d] !== 1'b0) begin
      fails++;
      $display("FAIL %s response: rdata=%h err=%b ready=%b, want %h %b 0",
               name, resp_rdata_a[d], resp_error_a[d], req_ready_a[d], exp_rdata, exp_err);
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      tests++;
      if (resp_valid_a[d] !== 1'b1 || resp_rdata_a[d] !== exp_rdata ||
          resp_error_a[d] !== exp_err || req_ready_a[d] !== 1'b0) begin
        fails++;
        $display("FAIL %s stall%0d: valid=%b rdata=%h err=%b ready=%b, want 1 %h %b 0",
                 name, s, resp_valid_a[d], resp_rdata_a[d], resp_error_a[d], req_ready_a[d],
                 exp_rdata, exp_err);
      end
    end
    resp_ready_a[d] = 1'b1;
    @(posedge clk);
    #1;
    resp_ready_a[d] = 1'b0;
    @(negedge clk);
    tests++;
    if (resp_valid_a[d] !== 1'b0 || req_ready_a[d] !== 1'b1) begin
      fails++;
      $display("FAIL %s release: valid=%b ready=%b, want 0 1", name, resp_valid_a[d], req_ready_a[d]);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (req_ready_a[d] !== 1'b1 || resp_valid_a[d] !== 1'b0) begin
        fails++;
        $display("FAIL reset_release dut%0d: ready=%b valid=%b, want 1 0", d, req_ready_a[d], resp_valid_a[d]);
      end
    end
  endtask

  task automatic test_wait2();
    do_txn(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 3, 32'd0, 1'b0, 0, "w2_store");
    do_txn(0, 1'b0, 32'h0000_0010, 32'd0, 3, 32'hDEAD_BEEF, 1'b0, 0, "w2_load");
  endtask

  task automatic test_wait0();
    do_txn(1, 1'b1, 32'h0000_0000, 32'h0000_0005, 1, 32'd0, 1'b0, 0, "w0_store");
    do_txn(1, 1'b0, 32'h0000_0000, 32'd0, 1, 32'h0000_0005, 1'b0, 0, "w0_load");
  endtask

  task automatic test_range();
    do_txn(1, 1'b0, 32'h0000_4000, 32'd0, 1, 32'd0, 1'b1, 0, "oor_load");
    do_txn(1, 1'b1, 32'h0000_4000, 32'h0BAD_0BAD, 1, 32'd0, 1'b1, 0, "oor_store");
    do_txn(1, 1'b0, 32'h0000_0000, 32'd0, 1, 32'h0000_0005, 1'b0, 0, "oor_word0");
  endtask

  task automatic test_stall();
    do_txn(0, 1'b0, 32'h0000_0010, 32'd0, 3, 32'hDEAD_BEEF, 1'b0, 5, "stall_load");
  endtask

  task automatic test_reset_mid();
    do_txn(0, 1'b1, 32'h0000_0020, 32'h1111_1111, 3, 32'd0, 1'b0, 0, "mid_prior");
    @(negedge clk);
    req_valid_a[0] = 1'b1;
    req_write_a[0] = 1'b1;
    req_addr_a[0]  = 32'h0000_0020;
    req_wdata_a[0] = 32'h1234_5678;
    @(posedge clk);
    #1;
    req_valid_a[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    do_txn(0, 1'b0, 32'h0000_0020, 32'd0, 3, 32'h1111_1111, 1'b0, 0, "mid_after");
  endtask

  task automatic test_misalign();
`ifdef DMEM_MISALIGN_CHECK_EN
    do_txn(0, 1'b1, 32'h0000_0022, 32'hCAFE_F00D, 3, 32'd0, 1'b1, 0, "mis_store");
    do_txn(0, 1'b0, 32'h0000_0020, 32'd0, 3, 32'h1111_1111, 1'b0, 0, "mis_word");
`else
    do_txn(0, 1'b1, 32'h0000_0022, 32'hCAFE_F00D, 3, 32'd0, 1'b0, 0, "mis_store");
    do_txn(0, 1'b0, 32'h0000_0020, 32'd0, 3, 32'hCAFE_F00D, 1'b0, 0, "mis_word");
`endif
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid_a[d]  = 1'b0;
      req_write_a[d]  = 1'b0;
      req_addr_a[d]   = 32'd0;
      req_wdata_a[d]  = 32'd0;
      resp_ready_a[d] = 1'b0;
    end
    test_reset();
    test_wait2();
    test_wait0();
    test_range();
    test_stall();
    test_reset_mid();
    test_misalign();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
